// File: rtl/calc_pkg.sv
// Purpose: shared encodings for the sign-magnitude calculator (display state, FSM, ops, button indices).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

    // Values driven on the estado display output.
    localparam logic [2:0] EST_DESLIGADO = 3'd0;
    localparam logic [2:0] EST_LIGADO    = 3'd1;
    localparam logic [2:0] EST_SOMA      = 3'd2;
    localparam logic [2:0] EST_MULT      = 3'd3;
    localparam logic [2:0] EST_SUB       = 3'd4;
    localparam logic [2:0] EST_DIV       = 3'd5;

    // Bit positions inside the packed button vector.
    localparam int BTN_ON   = 0;
    localparam int BTN_SOMA = 1;
    localparam int BTN_SUB  = 2;
    localparam int BTN_MULT = 3;
    localparam int BTN_DIV  = 4;
    localparam int NBTN     = 5;

    typedef enum logic [1:0] {
        DESLIGADO = 2'd0,
        LIGADO    = 2'd1,
        DIV_RUN   = 2'd2,
        RESULTADO = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_SOMA = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_DIV  = 2'd3
    } op_t;

    // Display code shown while an op's result is (or is about to be) on r.
    function automatic logic [2:0] op_estado(input op_t op);
        case (op)
            OP_SOMA: op_estado = EST_SOMA;
            OP_SUB:  op_estado = EST_SUB;
            OP_MULT: op_estado = EST_MULT;
            default: op_estado = EST_DIV;
        endcase
    endfunction

endpackage

// File: rtl/div_seq.sv
// Purpose: unsigned restoring shift-subtract divider, one quotient bit per clock.
// Latency: operands load on the start edge, W step edges follow, done pulses for the cycle after the last step.
// Backpressure: none; start is only legal when idle, abort drops the operation with no done pulse.
//
// Ports: clk, rst_n; start (1-cycle pulse, captures dividend/divisor), abort;
//        done (1-cycle pulse), quotient[W-1:0], remainder[W-1:0] (valid while done is high and until next start).
module div_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          run;
    logic [CW-1:0] cnt;
    logic [W-1:0]  d_q;

    // The quotient register doubles as the dividend shift register: its MSB
    // shifts into the partial remainder while the new quotient bit enters at the LSB.
    logic [W:0]   partial;
    logic         ge;
    logic [W-1:0] rem_next;

    assign partial  = {remainder, quotient[W-1]};
    assign ge       = (partial >= {1'b0, d_q});
    // partial - d_q < d_q when ge, so the W-bit wrap-around subtraction is exact.
    assign rem_next = ge ? (partial[W-1:0] - d_q) : partial[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            d_q       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                run <= 1'b0;
            end else if (start) begin
                run       <= 1'b1;
                cnt       <= '0;
                d_q       <= divisor;
                quotient  <= dividend;
                remainder <= '0;
            end else if (run) begin
                remainder <= rem_next;
                quotient  <= {quotient[W-2:0], ge};
                cnt       <= cnt + CW'(1);
                if (cnt == LAST) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_sinal_mag.sv
// Purpose: sign-magnitude calculator (add/sub/mult/div) driven by active-low push buttons.
// Latency: soma/sub/mult and div-by-zero results one edge after the press edge; divide W+1 edges after it.
// Backpressure: busy during a divide; op presses are ignored while busy, on_off aborts.
//
// Ports: clk, rst_n; a/b + sa/sb operands; btn_* active-low buttons;
//        r/sr result, ra/rb/ssa/ssb operand echo, estado display code, busy, valid pulse, erro (div by zero).
module calc_sinal_mag
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sa,
    input  logic           sb,
    input  logic           btn_on_off,
    input  logic           btn_soma,
    input  logic           btn_sub,
    input  logic           btn_mult,
    input  logic           btn_div,
    output logic [2*W-1:0] r,
    output logic           sr,
    output logic [W-1:0]   ra,
    output logic [W-1:0]   rb,
    output logic           ssa,
    output logic           ssb,
    output logic [2:0]     estado,
    output logic           busy,
    output logic           valid,
    output logic           erro
);

    // ---------------------------------------------------------------- buttons
    logic [NBTN-1:0] btn_n;
    logic [NBTN-1:0] btn_q;
    logic [NBTN-1:0] press;

    assign btn_n = {btn_div, btn_mult, btn_sub, btn_soma, btn_on_off};
    // Falling edge of an active-low button; a held button yields one press.
    assign press = btn_q & ~btn_n;

    logic p_on;
    logic op_vld;
    op_t  op_sel;

    assign p_on = press[BTN_ON];

    // Op priority mult > sub > soma > div; on_off outranks all of them at the FSM.
    always_comb begin
        op_vld = 1'b1;
        op_sel = OP_SOMA;
        if (press[BTN_MULT])      op_sel = OP_MULT;
        else if (press[BTN_SUB])  op_sel = OP_SUB;
        else if (press[BTN_SOMA]) op_sel = OP_SOMA;
        else if (press[BTN_DIV])  op_sel = OP_DIV;
        else                      op_vld = 1'b0;
    end

    // ---------------------------------------------------------------- state
    state_t       state;
    op_t          op_q;
    logic         pend;     // latched soma/sub/mult or div-by-zero awaiting its result edge
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         sa_q;
    logic         sb_q;

    logic op_go;
    logic div_start;
    logic div_abort;

    assign op_go     = ((state == LIGADO) || (state == RESULTADO)) && !p_on && op_vld;
    assign div_start = op_go && (op_sel == OP_DIV) && (b != '0);
    assign div_abort = (state == DIV_RUN) && p_on;

    // ---------------------------------------------------------------- divider
    logic         div_done;
    logic [W-1:0] div_quo;
    logic [W-1:0] div_rem;

    div_seq #(.W(W)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (div_abort),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    logic [2*W-1:0] div_mag;
    assign div_mag = {div_rem, div_quo};

    // ---------------------------------------------------------------- add/sub/mult
    logic           sb_eff;
    logic [W:0]     add_mag;
    logic           add_sign;
    logic [2*W-1:0] mul_mag;
    logic [2*W-1:0] calc_mag;
    logic           calc_sign;

    assign mul_mag = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

    // Subtraction is addition with b's sign flipped; unlike signs subtract the
    // smaller magnitude from the larger and take the larger operand's sign.
    always_comb begin
        sb_eff = (op_q == OP_SUB) ? ~sb_q : sb_q;
        if (sa_q == sb_eff) begin
            add_mag  = {1'b0, a_q} + {1'b0, b_q};
            add_sign = sa_q;
        end else if (a_q >= b_q) begin
            add_mag  = {1'b0, a_q - b_q};
            add_sign = sa_q;
        end else begin
            add_mag  = {1'b0, b_q - a_q};
            add_sign = sb_eff;
        end
    end

    always_comb begin
        calc_mag  = '0;
        calc_sign = 1'b0;
        case (op_q)
            OP_SOMA, OP_SUB: begin
                calc_mag  = {{(W-1){1'b0}}, add_mag};
                calc_sign = add_sign;
            end
            OP_MULT: begin
                calc_mag  = mul_mag;
                calc_sign = sa_q ^ sb_q;
            end
            default: begin
                calc_mag  = '0;
                calc_sign = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= '1;
            state <= DESLIGADO;
            op_q  <= OP_SOMA;
            pend  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            r     <= '0;
            sr    <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
            erro  <= 1'b0;
        end else begin
            btn_q <= btn_n;
            valid <= 1'b0;
            case (state)
                DESLIGADO: begin
                    if (p_on) state <= LIGADO;
                end
                LIGADO, RESULTADO: begin
                    if (p_on) begin
                        state <= DESLIGADO;
                        pend  <= 1'b0;
                        r     <= '0;
                        sr    <= 1'b0;
                        erro  <= 1'b0;
                    end else if (op_go) begin
                        // A new op overrides any result still pending; r holds.
                        a_q  <= a;
                        b_q  <= b;
                        sa_q <= sa;
                        sb_q <= sb;
                        op_q <= op_sel;
                        erro <= 1'b0;
                        if (div_start) begin
                            state <= DIV_RUN;
                            busy  <= 1'b1;
                            pend  <= 1'b0;
                        end else begin
                            state <= RESULTADO;
                            pend  <= 1'b1;
                        end
                    end else if (pend) begin
                        pend  <= 1'b0;
                        valid <= 1'b1;
                        if (op_q == OP_DIV) begin
                            // Only a zero divisor reaches here as a pending div.
                            r    <= '0;
                            sr   <= 1'b0;
                            erro <= 1'b1;
                        end else begin
                            r  <= calc_mag;
                            sr <= calc_sign & (|calc_mag);
                        end
                    end
                end
                DIV_RUN: begin
                    if (p_on) begin
                        state <= DESLIGADO;
                        busy  <= 1'b0;
                        r     <= '0;
                        sr    <= 1'b0;
                        erro  <= 1'b0;
                    end else if (div_done) begin
                        state <= RESULTADO;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        r     <= div_mag;
                        sr    <= (sa_q ^ sb_q) & (|div_mag);
                    end
                end
                default: state <= DESLIGADO;
            endcase
        end
    end

    // ---------------------------------------------------------------- display outputs
    always_comb begin
        ra     = '0;
        rb     = '0;
        ssa    = 1'b0;
        ssb    = 1'b0;
        estado = EST_DESLIGADO;
        case (state)
            LIGADO: begin
                ra     = a;
                rb     = b;
                ssa    = sa;
                ssb    = sb;
                estado = EST_LIGADO;
            end
            DIV_RUN: begin
                ra     = a_q;
                rb     = b_q;
                ssa    = sa_q;
                ssb    = sb_q;
                estado = EST_DIV;
            end
            RESULTADO: begin
                ra     = a_q;
                rb     = b_q;
                ssa    = sa_q;
                ssb    = sb_q;
                estado = op_estado(op_q);
            end
            default: begin
                estado = EST_DESLIGADO;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_sinal_mag.sv
// Purpose: directed bench for calc_sinal_mag with an expected-result queue and a valid-driven monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_calc_sinal_mag;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   a, b;
    logic           sa, sb;
    logic           btn_on_off, btn_soma, btn_sub, btn_mult, btn_div;
    logic [2*W-1:0] r;
    logic           sr;
    logic [W-1:0]   ra, rb;
    logic           ssa, ssb;
    logic [2:0]     estado;
    logic           busy, valid, erro;

    calc_sinal_mag #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .sa         (sa),
        .sb         (sb),
        .btn_on_off (btn_on_off),
        .btn_soma   (btn_soma),
        .btn_sub    (btn_sub),
        .btn_mult   (btn_mult),
        .btn_div    (btn_div),
        .r          (r),
        .sr         (sr),
        .ra         (ra),
        .rb         (rb),
        .ssa        (ssa),
        .ssb        (ssb),
        .estado     (estado),
        .busy       (busy),
        .valid      (valid),
        .erro       (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] r;
        logic           sr;
        logic           erro;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int nvec      = 0;
    int errs      = 0;
    int valid_cnt = 0;

    localparam int B_ON   = 0;
    localparam int B_SOMA = 1;
    localparam int B_SUB  = 2;
    localparam int B_MULT = 3;
    localparam int B_DIV  = 4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            B_ON:    btn_on_off = v;
            B_SOMA:  btn_soma   = v;
            B_SUB:   btn_sub    = v;
            B_MULT:  btn_mult   = v;
            default: btn_div    = v;
        endcase
    endtask

    task automatic expect_res(input logic [2*W-1:0] er, input logic es, input logic ee);
        exp_t e;
        e.r    = er;
        e.sr   = es;
        e.erro = ee;
        exp_q.push_back(e);
    endtask

    // Drive operands and hold one button low across exactly one rising edge.
    // Returns at the falling edge just after edge k.
    task automatic press(input int idx, input logic [W-1:0] va, input logic vsa,
                         input logic [W-1:0] vb, input logic vsb);
        @(negedge clk);
        a  = va;
        sa = vsa;
        b  = vb;
        sb = vsb;
        set_btn(idx, 1'b0);
        @(negedge clk);
        set_btn(idx, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every valid pulse pops one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                nvec++;
                errs++;
                $display("FAIL unexpected_valid: got r=%0h sr=%0b erro=%0b, expected no result", r, sr, erro);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_r", 32'(r), 32'(mon_e.r));
                check("result_sr", 32'(sr), 32'(mon_e.sr));
                check("result_erro", 32'(erro), 32'(mon_e.erro));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        int vc0;

        rst_n = 1'b0;
        a = '0; b = '0; sa = 1'b0; sb = 1'b0;
        btn_on_off = 1'b1; btn_soma = 1'b1; btn_sub = 1'b1; btn_mult = 1'b1; btn_div = 1'b1;
        idle(3);
        check("rst_r", 32'(r), 32'h0);
        check("rst_sr", 32'(sr), 32'h0);
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_erro", 32'(erro), 32'h0);
        check("rst_ra", 32'(ra), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Power on; operand echo follows live inputs.
        press(B_ON, 8'd17, 1'b1, 8'd4, 1'b0);
        check("on_estado", 32'(estado), 32'd1);
        check("ligado_ra_live", 32'(ra), 32'd17);
        check("ligado_ssa_live", 32'(ssa), 32'd1);

        // soma 5 + (-3) = 2, valid exactly at k+1.
        expect_res(16'd2, 1'b0, 1'b0);
        press(B_SOMA, 8'd5, 1'b0, 8'd3, 1'b1);
        check("soma_estado", 32'(estado), 32'd2);
        check("soma_valid_at_k", 32'(valid), 32'h0);
        b = 8'd99;
        @(negedge clk);
        check("soma_valid_at_k1", 32'(valid), 32'h1);
        check("soma_rb_latched", 32'(rb), 32'd3);
        @(negedge clk);
        check("soma_valid_one_cycle", 32'(valid), 32'h0);
        idle(2);

        // sub: -5 - 7 = -12; 9 - 9 = 0 with positive sign.
        expect_res(16'd12, 1'b1, 1'b0);
        press(B_SUB, 8'd5, 1'b1, 8'd7, 1'b0);
        check("sub_estado", 32'(estado), 32'd4);
        idle(3);
        expect_res(16'd0, 1'b0, 1'b0);
        press(B_SUB, 8'd9, 1'b0, 8'd9, 1'b0);
        idle(3);

        // mult: -12 * 13 = -156; 0 * -3 normalises to +0.
        expect_res(16'd156, 1'b1, 1'b0);
        press(B_MULT, 8'd12, 1'b1, 8'd13, 1'b0);
        check("mult_estado", 32'(estado), 32'd3);
        idle(3);
        expect_res(16'd0, 1'b0, 1'b0);
        press(B_MULT, 8'd0, 1'b0, 8'd3, 1'b1);
        idle(3);

        // div 200 / 7 = 28 rem 4; soma press during busy must be ignored.
        expect_res(16'h041C, 1'b0, 1'b0);
        press(B_DIV, 8'd200, 1'b0, 8'd7, 1'b0);
        check("div_busy_at_k", 32'(busy), 32'h1);
        check("div_estado", 32'(estado), 32'd5);
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 50) begin
            bcnt++;
            if (bcnt == 3) btn_soma = 1'b0;
            if (bcnt == 4) btn_soma = 1'b1;
            @(negedge clk);
        end
        check("div_busy_cycles", 32'(bcnt), 32'd9);
        check("div_estado_after", 32'(estado), 32'd5);
        idle(3);

        // Divide by zero: error at k+1, busy never set; next op clears erro.
        expect_res(16'd0, 1'b0, 1'b1);
        press(B_DIV, 8'd50, 1'b1, 8'd0, 1'b0);
        check("div0_busy_k", 32'(busy), 32'h0);
        @(negedge clk);
        check("div0_erro", 32'(erro), 32'h1);
        check("div0_busy_k1", 32'(busy), 32'h0);
        idle(2);
        expect_res(16'd6, 1'b0, 1'b0);
        press(B_MULT, 8'd2, 1'b0, 8'd3, 1'b0);
        check("erro_cleared", 32'(erro), 32'h0);
        idle(3);

        // Abort a divide with on_off: no result, everything zero.
        vc0 = valid_cnt;
        press(B_DIV, 8'd100, 1'b0, 8'd3, 1'b0);
        idle(2);
        press(B_ON, 8'd100, 1'b0, 8'd3, 1'b0);
        check("abort_estado", 32'(estado), 32'd0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_r", 32'(r), 32'h0);
        check("abort_ra", 32'(ra), 32'h0);
        idle(15);
        check("abort_no_valid", 32'(valid_cnt - vc0), 32'd0);

        // Op presses while off do nothing.
        press(B_MULT, 8'd4, 1'b0, 8'd5, 1'b0);
        press(B_DIV, 8'd4, 1'b0, 8'd5, 1'b0);
        idle(3);
        check("off_estado", 32'(estado), 32'd0);
        check("off_r", 32'(r), 32'h0);
        check("off_no_valid", 32'(valid_cnt - vc0), 32'd0);

        // Held mult button: one result only.
        press(B_ON, 8'd0, 1'b0, 8'd0, 1'b0);
        expect_res(16'd12, 1'b0, 1'b0);
        vc0 = valid_cnt;
        @(negedge clk);
        a = 8'd3; sa = 1'b0; b = 8'd4; sb = 1'b0;
        btn_mult = 1'b0;
        idle(10);
        btn_mult = 1'b1;
        idle(3);
        check("hold_one_valid", 32'(valid_cnt - vc0), 32'd1);
        check("hold_r", 32'(r), 32'd12);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
